// File: rtl/ps2_key_tracker_pkg.sv
// Shared types and constants for the PS/2 key tracker: frame/decoder states,
// Set-2 prefix bytes, the ignored-code list and the key index width.
package ps2_pkg;

  localparam int unsigned KEY_IDX_W = 9;
  localparam int unsigned KEY_MAP_W = 1 << KEY_IDX_W;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_EXT,
    D_BRK,
    D_EXT_BRK
  } dec_state_t;

  // Keyboard status/acknowledge bytes that never describe a key.
  function automatic logic is_ignored(input logic [7:0] code);
    case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Key-state interface published to the game logic; the tracker drives the
// master side, consumers attach to the slave side.
interface ps2_key_tracker_if;
  import ps2_pkg::*;

  logic [KEY_MAP_W-1:0] key_down;
  logic [KEY_IDX_W-1:0] last_change;
  logic                 been_ready;
  logic                 parity_err;

  modport master (output key_down, output last_change, output been_ready, output parity_err);
  modport slave  (input  key_down, input  last_change, input  been_ready, input  parity_err);
endinterface

// File: rtl/ps2_key_tracker_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizer, clock glitch filter, frame
// FSM with idle timeout. Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       CLK100MHZ,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       parity_err,
  output logic       rx_timeout
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif

  // Idle-high line: synchronizers and filter come out of reset at 1 so no false edge.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DATA;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_filt && !clk_s2 && (filt_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tmo_d      = (state_q == RX_IDLE || fall) ? '0 : tmo_q + 1'b1;
    byte_valid = 1'b0;
    parity_err = 1'b0;
    rx_timeout = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d      = par_q;
`endif
    if (state_q != RX_IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      rx_timeout = 1'b1;
      state_d    = RX_IDLE;
      tmo_d      = '0;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_s2) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_s2, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s2;
`endif
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
`ifdef PS2_PARITY_CHECK_EN
          if (!(^{shift_q, par_q})) parity_err = 1'b1;
          else                      byte_valid = dat_s2;
`else
          byte_valid = dat_s2;
`endif
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Set-2 scancode decoder and 512-bit key-held bitmap fed by ps2_frame_rx.
// Optional parity enforcement: define PS2_PARITY_CHECK_EN.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic               CLK100MHZ,
  input  logic               RESET,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  ps2_key_tracker_if.master  key_if
);

  logic       byte_valid, rx_perr, rx_timeout;
  logic [7:0] rx_byte;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .CLK100MHZ  (CLK100MHZ),
    .RESET      (RESET),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .parity_err (rx_perr),
    .rx_timeout (rx_timeout)
  );

  dec_state_t           dec_q, dec_d;
  logic                 upd, upd_make;
  logic [KEY_IDX_W-1:0] upd_idx;
  logic [KEY_MAP_W-1:0] key_down_q;
  logic [KEY_IDX_W-1:0] last_change_q;
  logic                 been_ready_q, parity_err_q;

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) dec_q <= D_IDLE;
    else       dec_q <= dec_d;
  end

  always_comb begin
    dec_d    = dec_q;
    upd      = 1'b0;
    upd_make = 1'b0;
    upd_idx  = '0;
    if (rx_timeout) begin
      dec_d = D_IDLE;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        if (dec_q == D_IDLE) dec_d = D_EXT;
      end else if (rx_byte == PS2_BRK) begin
        if (dec_q == D_IDLE)     dec_d = D_BRK;
        else if (dec_q == D_EXT) dec_d = D_EXT_BRK;
      end else if (rx_byte == PS2_PAUSE) begin
        dec_d = dec_q;
      end else if (is_ignored(rx_byte)) begin
        dec_d = D_IDLE;
      end else begin
        upd      = 1'b1;
        upd_make = (dec_q == D_IDLE) || (dec_q == D_EXT);
        upd_idx  = {(dec_q == D_EXT) || (dec_q == D_EXT_BRK), rx_byte};
        dec_d    = D_IDLE;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      key_down_q    <= '0;
      last_change_q <= '0;
      been_ready_q  <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      been_ready_q <= upd;
      parity_err_q <= rx_perr;
      if (upd) begin
        key_down_q[upd_idx] <= upd_make;
        last_change_q       <= upd_idx;
      end
    end
  end

  assign key_if.key_down    = key_down_q;
  assign key_if.last_change = last_change_q;
  assign key_if.been_ready  = been_ready_q;
  assign key_if.parity_err  = parity_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: drives PS/2 frames and compares
// every been_ready strobe against a queue of expected key events.
module tb_ps2_key_tracker;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic PS2_CLK = 1'b1;
  logic PS2_DATA = 1'b1;

  always #5 clk = ~clk;

  ps2_key_tracker_if key_if ();

  ps2_key_tracker #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (20000)
  ) dut (
    .CLK100MHZ (clk),
    .RESET     (RESET),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .key_if    (key_if)
  );

  typedef struct {
    logic [8:0]   idx;
    logic [511:0] map;
  } sb_t;

  sb_t          sb[$];
  sb_t          ent;
  logic [511:0] exp_map = '0;
  int           n_checks = 0;
  int           n_fails = 0;
  int           perr_seen = 0;
  int           exp_perr = 0;
  int           wide = 0;
  logic         prev_br = 1'b0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    PS2_DATA = b;
    wait_cyc(25);
    PS2_CLK = 1'b0;
    wait_cyc(50);
    PS2_CLK = 1'b1;
    wait_cyc(25);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic p;
    p = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(1'b1);
    wait_cyc(20);
  endtask

  // Expectation is queued just before the final byte so any strobe on a prefix byte hits an empty queue.
  task automatic key_event(input logic ext, input logic brk, input logic [7:0] code);
    sb_t e;
    if (ext) send_frame(8'hE0, 1'b0);
    if (brk) send_frame(8'hF0, 1'b0);
    e.idx = {ext, code};
    exp_map[e.idx] = ~brk;
    e.map = exp_map;
    sb.push_back(e);
    send_frame(code, 1'b0);
    check_eq("sb_drained", sb.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_key_down"}, key_if.key_down, '0);
    check_eq({tag, "_last_change"}, key_if.last_change, '0);
    check_eq({tag, "_been_ready"}, key_if.been_ready, 0);
    check_eq({tag, "_parity_err"}, key_if.parity_err, 0);
  endtask

  always @(negedge clk) begin
    if (!RESET) begin
      if (key_if.parity_err) perr_seen++;
      if (key_if.been_ready) begin
        if (prev_br) wide++;
        if (sb.size() == 0) begin
          check_eq("unexpected_strobe", key_if.been_ready, 0);
        end else begin
          ent = sb.pop_front();
          check_eq("last_change", key_if.last_change, ent.idx);
          check_eq("key_down", key_if.key_down, ent.map);
        end
      end
    end
    prev_br = key_if.been_ready;
  end

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_cyc(5);
    RESET = 1'b0;
    wait_cyc(2);
    check_reset_state("reset");

    key_event(1'b0, 1'b0, 8'h1D);
    key_event(1'b0, 1'b1, 8'h1D);

    key_event(1'b1, 1'b0, 8'h75);
    key_event(1'b0, 1'b0, 8'h75);
    key_event(1'b1, 1'b1, 8'h75);

    key_event(1'b0, 1'b0, 8'h75);
    key_event(1'b0, 1'b1, 8'h1C);

    // An ignored code between the prefix and the key drops the prefix.
    send_frame(8'hE0, 1'b0);
    send_frame(8'hAA, 1'b0);
    key_event(1'b0, 1'b0, 8'h6B);

`ifdef PS2_PARITY_CHECK_EN
    exp_perr++;
    send_frame(8'h29, 1'b1);
    check_eq("perr_map", key_if.key_down, exp_map);
`else
    ent.idx = 9'h029;
    exp_map[9'h029] = 1'b1;
    ent.map = exp_map;
    sb.push_back(ent);
    send_frame(8'h29, 1'b1);
`endif
    check_eq("perr_drained", sb.size(), 0);
    check_eq("perr_count", perr_seen, exp_perr);

    PS2_CLK = 1'b0;
    wait_cyc(3);
    PS2_CLK = 1'b1;
    wait_cyc(30);
    key_event(1'b0, 1'b0, 8'h1B);

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_cyc(25000);
    key_event(1'b0, 1'b0, 8'h29);
    check_eq("key_029", key_if.key_down[9'h029], 1);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    RESET = 1'b1;
    wait_cyc(1);
    check_reset_state("midreset");
    RESET = 1'b0;
    exp_map = '0;
    wait_cyc(30);
    key_event(1'b0, 1'b0, 8'h1D);

    check_eq("strobe_width", wide, 0);
    check_eq("perr_final", perr_seen, exp_perr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
